// File: rtl/pre_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : pre_mem_stage
// Brief    : EX->MEM stage that issues aligned, formatted data-SRAM requests
//            and drains flushed requests so none are left orphaned.
// Revision : 1.0 - initial release
// ============================================================================
module pre_mem_stage #(
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es_valid,
  input  logic [3:0]           es_mem_op,
  input  logic [31:0]          es_addr,
  input  logic [31:0]          es_wdata,
  input  logic                 es_ex,
  input  logic [PAYLOAD_W-1:0] es_payload,
  output logic                 pms_allowin,
  input  logic                 ms_allowin,
  input  logic                 flush,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [31:0]          data_addr,
  output logic [3:0]           data_wstrb,
  output logic [31:0]          data_wdata,
  input  logic                 data_addr_ok,
  output logic                 pms_to_ms_valid,
  output logic                 pms_req_ok,
  output logic [3:0]           pms_mem_op,
  output logic [31:0]          pms_addr,
  output logic                 pms_ex,
  output logic [1:0]           pms_ade,
  output logic [PAYLOAD_W-1:0] pms_payload
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_SENT  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic                 r_valid;
  logic [3:0]           r_mem_op;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_ex;
  logic [PAYLOAD_W-1:0] r_payload;

  logic       w_load, w_store, w_misalign, w_ex, w_need_req;
  logic       w_ready_go, w_allowin, w_es_need, w_entry, w_entry_req;
  logic [1:0] w_ade;

  // Size 3 is illegal and behaves as a word access.
  function automatic logic f_misalign(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'd1) & a[0]) | (size[1] & (a != 2'd0));
  endfunction

  assign w_load      = r_mem_op[3];
  assign w_store     = r_mem_op[2];
  assign w_misalign  = f_misalign(r_mem_op[1:0], r_addr[1:0]);
  assign w_ade       = {w_load & w_misalign, w_store & w_misalign};
  assign w_ex        = r_ex | (|w_ade);
  assign w_need_req  = r_valid & (w_load | w_store) & ~w_ex;

  // Lookahead on the incoming instruction so WAIT is entered the cycle after entry.
  assign w_es_need   = es_valid & (es_mem_op[3] | es_mem_op[2]) & ~es_ex
                     & ~f_misalign(es_mem_op[1:0], es_addr[1:0]);
  assign w_entry     = es_valid & w_allowin & ~flush;
  assign w_entry_req = w_entry & w_es_need;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= c_IDLE;
      r_valid   <= 1'b0;
      r_mem_op  <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_ex      <= 1'b0;
      r_payload <= '0;
    end else begin
      r_state <= w_next;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_allowin) begin
        r_valid <= es_valid;
      end
      if (w_entry) begin
        r_mem_op  <= es_mem_op;
        r_addr    <= es_addr;
        r_wdata   <= es_wdata;
        r_ex      <= es_ex;
        r_payload <= es_payload;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_entry_req) w_next = c_WAIT;
      end
      c_WAIT: begin
        if (data_addr_ok) begin
          if (flush)           w_next = c_IDLE;
          else if (ms_allowin) w_next = w_entry_req ? c_WAIT : c_IDLE;
          else                 w_next = c_SENT;
        end else if (flush) begin
          w_next = c_DRAIN;
        end
      end
      c_SENT: begin
        if (flush)           w_next = c_IDLE;
        else if (ms_allowin) w_next = w_entry_req ? c_WAIT : c_IDLE;
      end
      c_DRAIN: begin
        if (data_addr_ok) w_next = c_IDLE;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_ready_go = ~w_need_req | (r_state == c_SENT) | ((r_state == c_WAIT) & data_addr_ok);
    w_allowin  = (~r_valid | (w_ready_go & ms_allowin)) & (r_state != c_DRAIN);
    data_req   = (r_state == c_WAIT) | (r_state == c_DRAIN);
    // A drained request still owes a response, so MEM must learn to cancel it.
    pms_req_ok = (r_valid & ((r_state == c_SENT) | ((r_state == c_WAIT) & data_addr_ok)))
               | ((r_state == c_DRAIN) & data_addr_ok);
    pms_to_ms_valid = r_valid & w_ready_go;
  end

  always_comb begin
    data_wstrb = 4'b0000;
    if (w_store) begin
      case (r_mem_op[1:0])
        2'd0:    data_wstrb = 4'b0001 << r_addr[1:0];
        2'd1:    data_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        default: data_wstrb = 4'b1111;
      endcase
    end
    case (r_mem_op[1:0])
      2'd0:    data_wdata = {4{r_wdata[7:0]}};
      2'd1:    data_wdata = {2{r_wdata[15:0]}};
      default: data_wdata = r_wdata;
    endcase
  end

  assign pms_allowin = w_allowin;
  assign data_wr     = w_store;
  assign data_size   = r_mem_op[1:0];
  assign data_addr   = r_addr;
  assign pms_mem_op  = r_mem_op;
  assign pms_addr    = r_addr;
  assign pms_ex      = w_ex;
  assign pms_ade     = w_ade;
  assign pms_payload = r_payload;

endmodule
`default_nettype wire

// File: tb/tb_pre_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pre_mem_stage
// Brief    : Directed vector table plus multi-cycle handshake/flush sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pre_mem_stage;

  localparam int PAYLOAD_W = 128;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 es_valid;
  logic [3:0]           es_mem_op;
  logic [31:0]          es_addr;
  logic [31:0]          es_wdata;
  logic                 es_ex;
  logic [PAYLOAD_W-1:0] es_payload;
  logic                 pms_allowin;
  logic                 ms_allowin;
  logic                 flush;
  logic                 data_req;
  logic                 data_wr;
  logic [1:0]           data_size;
  logic [31:0]          data_addr;
  logic [3:0]           data_wstrb;
  logic [31:0]          data_wdata;
  logic                 data_addr_ok;
  logic                 pms_to_ms_valid;
  logic                 pms_req_ok;
  logic [3:0]           pms_mem_op;
  logic [31:0]          pms_addr;
  logic                 pms_ex;
  logic [1:0]           pms_ade;
  logic [PAYLOAD_W-1:0] pms_payload;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pre_mem_stage #(.PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .resetn(resetn), .es_valid(es_valid), .es_mem_op(es_mem_op),
    .es_addr(es_addr), .es_wdata(es_wdata), .es_ex(es_ex), .es_payload(es_payload),
    .pms_allowin(pms_allowin), .ms_allowin(ms_allowin), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .pms_to_ms_valid(pms_to_ms_valid),
    .pms_req_ok(pms_req_ok), .pms_mem_op(pms_mem_op), .pms_addr(pms_addr),
    .pms_ex(pms_ex), .pms_ade(pms_ade), .pms_payload(pms_payload)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ex;
    logic        req;
    logic [3:0]  wstrb;
    logic [31:0] dwd;
    logic [1:0]  ade;
    logic        pex;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic ex);
    es_valid  = v;
    es_mem_op = op;
    es_addr   = a;
    es_wdata  = wd;
    es_ex     = ex;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'b1010, 32'h1000, 32'hDEADBEEF, 1'b0, 1'b1, 4'b0000, 32'hDEADBEEF, 2'b00, 1'b0};
    vt[1]  = '{4'b0100, 32'h1003, 32'h000000AB, 1'b0, 1'b1, 4'b1000, 32'hABABABAB, 2'b00, 1'b0};
    vt[2]  = '{4'b0101, 32'h1002, 32'h00001234, 1'b0, 1'b1, 4'b1100, 32'h12341234, 2'b00, 1'b0};
    vt[3]  = '{4'b1010, 32'h1002, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'b10, 1'b1};
    vt[4]  = '{4'b0101, 32'h1001, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'b01, 1'b1};
    vt[5]  = '{4'b0100, 32'h1000, 32'h12345678, 1'b0, 1'b1, 4'b0001, 32'h78787878, 2'b00, 1'b0};
    vt[6]  = '{4'b0101, 32'h1000, 32'hCAFEBEEF, 1'b0, 1'b1, 4'b0011, 32'hBEEFBEEF, 2'b00, 1'b0};
    vt[7]  = '{4'b0110, 32'h2004, 32'h11223344, 1'b0, 1'b1, 4'b1111, 32'h11223344, 2'b00, 1'b0};
    vt[8]  = '{4'b1010, 32'h1000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 32'h00000000, 2'b00, 1'b1};
    vt[9]  = '{4'b0000, 32'h1003, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'b00, 1'b0};
    vt[10] = '{4'b1011, 32'h1001, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'b10, 1'b1};
    vt[11] = '{4'b1000, 32'h1003, 32'h00000055, 1'b0, 1'b1, 4'b0000, 32'h55555555, 2'b00, 1'b0};
    vt[12] = '{4'b0110, 32'h2002, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'b01, 1'b1};

    resetn = 1'b0; flush = 1'b0; ms_allowin = 1'b1; data_addr_ok = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    es_payload = '0;
    repeat (3) cyc();
    #1;
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_to_ms_valid", 32'(pms_to_ms_valid), 32'd0);
    chk("rst_req_ok", 32'(pms_req_ok), 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_ex", 32'(pms_ex), 32'd0);
    cyc(); resetn = 1'b1;

    // Single-instruction vectors, SRAM and MEM always ready.
    data_addr_ok = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      drive(1'b1, vt[i].op, vt[i].addr, vt[i].wd, vt[i].ex);
      es_payload = PAYLOAD_W'(32'h5A00 + i);
      cyc();
      es_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_to_ms_valid", i), 32'(pms_to_ms_valid), 32'd1);
      chk($sformatf("v%0d_data_req", i), 32'(data_req), 32'(vt[i].req));
      chk($sformatf("v%0d_req_ok", i), 32'(pms_req_ok), 32'(vt[i].req));
      chk($sformatf("v%0d_ade", i), 32'(pms_ade), 32'(vt[i].ade));
      chk($sformatf("v%0d_ex", i), 32'(pms_ex), 32'(vt[i].pex));
      chk($sformatf("v%0d_payload", i), pms_payload[31:0], 32'h5A00 + i);
      chk($sformatf("v%0d_pms_addr", i), pms_addr, vt[i].addr);
      if (vt[i].req) begin
        chk($sformatf("v%0d_wr", i), 32'(data_wr), 32'(vt[i].op[2]));
        chk($sformatf("v%0d_size", i), 32'(data_size), 32'(vt[i].op[1:0]));
        chk($sformatf("v%0d_wstrb", i), 32'(data_wstrb), 32'(vt[i].wstrb));
        chk($sformatf("v%0d_wdata", i), data_wdata, vt[i].dwd);
        chk($sformatf("v%0d_addr", i), data_addr, vt[i].addr);
      end
      cyc(); #1;
      chk($sformatf("v%0d_req_after", i), 32'(data_req), 32'd0);
      chk($sformatf("v%0d_valid_after", i), 32'(pms_to_ms_valid), 32'd0);
    end

    // Delayed acceptance then MEM backpressure.
    cyc();
    data_addr_ok = 1'b0; ms_allowin = 1'b0;
    drive(1'b1, 4'b1010, 32'h3000, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      es_valid = 1'b0;
      data_addr_ok = (c == 4);
      #1;
      chk($sformatf("a%0d_data_req", c), 32'(data_req), 32'd1);
      chk($sformatf("a%0d_addr", c), data_addr, 32'h3000);
      chk($sformatf("a%0d_allowin", c), 32'(pms_allowin), 32'd0);
      chk($sformatf("a%0d_to_ms", c), 32'(pms_to_ms_valid), 32'(c == 4));
      chk($sformatf("a%0d_req_ok", c), 32'(pms_req_ok), 32'(c == 4));
    end
    cyc(); data_addr_ok = 1'b0; #1;
    chk("a5_sent_req", 32'(data_req), 32'd0);
    chk("a5_sent_req_ok", 32'(pms_req_ok), 32'd1);
    chk("a5_sent_allowin", 32'(pms_allowin), 32'd0);
    cyc(); ms_allowin = 1'b1; #1;
    chk("a6_to_ms", 32'(pms_to_ms_valid), 32'd1);
    chk("a6_allowin", 32'(pms_allowin), 32'd1);
    cyc(); #1;
    chk("a7_idle_to_ms", 32'(pms_to_ms_valid), 32'd0);
    chk("a7_idle_req", 32'(data_req), 32'd0);

    // Flush while waiting for acceptance: request drains.
    cyc();
    drive(1'b1, 4'b0110, 32'h4000, 32'hA5A5_0F0F, 1'b0);
    cyc();
    es_valid = 1'b0; flush = 1'b1; #1;
    chk("f1_data_req", 32'(data_req), 32'd1);
    cyc(); flush = 1'b0; #1;
    chk("f2_data_req", 32'(data_req), 32'd1);
    chk("f2_allowin", 32'(pms_allowin), 32'd0);
    chk("f2_to_ms", 32'(pms_to_ms_valid), 32'd0);
    chk("f2_addr", data_addr, 32'h4000);
    chk("f2_wdata", data_wdata, 32'hA5A5_0F0F);
    chk("f2_req_ok", 32'(pms_req_ok), 32'd0);
    cyc(); data_addr_ok = 1'b1; #1;
    chk("f3_data_req", 32'(data_req), 32'd1);
    chk("f3_req_ok", 32'(pms_req_ok), 32'd1);
    chk("f3_to_ms", 32'(pms_to_ms_valid), 32'd0);
    chk("f3_allowin", 32'(pms_allowin), 32'd0);
    cyc(); data_addr_ok = 1'b0; #1;
    chk("f4_data_req", 32'(data_req), 32'd0);
    chk("f4_allowin", 32'(pms_allowin), 32'd1);
    chk("f4_req_ok", 32'(pms_req_ok), 32'd0);

    // Back-to-back loads at full throughput.
    data_addr_ok = 1'b1; ms_allowin = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      cyc();
      if (i < 4) drive(1'b1, 4'b1010, 32'h5000 + 32'(4 * i), 32'h0, 1'b0);
      else       es_valid = 1'b0;
      #1;
      if (i > 0) begin
        chk($sformatf("b%0d_data_req", i), 32'(data_req), 32'd1);
        chk($sformatf("b%0d_addr", i), data_addr, 32'h5000 + 32'(4 * (i - 1)));
        chk($sformatf("b%0d_to_ms", i), 32'(pms_to_ms_valid), 32'd1);
        chk($sformatf("b%0d_allowin", i), 32'(pms_allowin), 32'd1);
      end
    end
    cyc(); #1;
    chk("b5_data_req", 32'(data_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
